// File: rtl/traffic_ctrl.sv
// Two-road traffic-light controller with tick enable, all-red clearance,
// pedestrian shortening of main green, night flash mode and countdown.
// Ports: clk, rst_n (async, low); ped_req, flash_en in;
//        light_a_n/light_b_n {r,y,g} active-low, walk, ped_pend,
//        countdown (ticks left, 0 in FLASH), state (debug).
module traffic_ctrl #(
   parameter int TICK_DIV  = 12000000,
   parameter int T_GREEN_A = 10,
   parameter int T_GREEN_B = 8,
   parameter int T_YELLOW  = 3,
   parameter int T_ALLRED  = 1,
   parameter int T_PED_MIN = 3,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ped_req,
   input  logic             flash_en,
   output logic [2:0]       light_a_n,
   output logic [2:0]       light_b_n,
   output logic             walk,
   output logic             ped_pend,
   output logic [CNT_W-1:0] countdown,
   output logic [2:0]       state
);

   localparam logic [2:0] S_GA  = 3'd0;
   localparam logic [2:0] S_YA  = 3'd1;
   localparam logic [2:0] S_AR1 = 3'd2;
   localparam logic [2:0] S_GB  = 3'd3;
   localparam logic [2:0] S_YB  = 3'd4;
   localparam logic [2:0] S_AR2 = 3'd5;
   localparam logic [2:0] S_FL  = 3'd6;

   localparam int TW = $clog2(TICK_DIV);

   localparam logic [CNT_W-1:0] C_GA  = CNT_W'(T_GREEN_A);
   localparam logic [CNT_W-1:0] C_GB  = CNT_W'(T_GREEN_B);
   localparam logic [CNT_W-1:0] C_Y   = CNT_W'(T_YELLOW);
   localparam logic [CNT_W-1:0] C_AR  = CNT_W'(T_ALLRED);
   localparam logic [CNT_W-1:0] C_PED = CNT_W'(T_PED_MIN);
   localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

   localparam logic [2:0] L_RED = 3'b011;
   localparam logic [2:0] L_YEL = 3'b101;
   localparam logic [2:0] L_GRN = 3'b110;
   localparam logic [2:0] L_OFF = 3'b111;

   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic [2:0]       state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             tog_q;
   logic [2:0]       nxt_state;
   logic [CNT_W-1:0] nxt_cnt;
   logic             nxt_tog;
   logic             clr_pend;

   assign tick      = (tick_cnt == TW'(TICK_DIV - 1));
   assign state     = state_q;
   assign countdown = cnt_q;

   function automatic logic [2:0] lamp_a(input logic [2:0] s,
                                         input logic t);
      case (s)
         S_GA:    lamp_a = L_GRN;
         S_YA:    lamp_a = L_YEL;
         S_FL:    lamp_a = t ? L_YEL : L_OFF;
         default: lamp_a = L_RED;
      endcase
   endfunction

   function automatic logic [2:0] lamp_b(input logic [2:0] s,
                                         input logic t);
      case (s)
         S_GB:    lamp_b = L_GRN;
         S_YB:    lamp_b = L_YEL;
         S_FL:    lamp_b = t ? L_YEL : L_OFF;
         default: lamp_b = L_RED;
      endcase
   endfunction

   always_comb begin
      nxt_state = state_q;
      nxt_cnt   = cnt_q;
      nxt_tog   = tog_q;
      if (tick) begin
         case (state_q)
            S_GA: begin
               if (flash_en || cnt_q == C_ONE) begin
                  nxt_state = S_YA;
                  nxt_cnt   = C_Y;
               end else if (ped_pend && cnt_q > C_PED) begin
                  // Once loaded, cnt <= C_PED so this cannot repeat.
                  nxt_cnt = C_PED;
               end else begin
                  nxt_cnt = cnt_q - C_ONE;
               end
            end
            S_YA: begin
               if (cnt_q == C_ONE) begin
                  nxt_state = S_AR1;
                  nxt_cnt   = C_AR;
               end else begin
                  nxt_cnt = cnt_q - C_ONE;
               end
            end
            S_AR1: begin
               if (cnt_q == C_ONE && flash_en) begin
                  nxt_state = S_FL;
                  nxt_cnt   = '0;
                  nxt_tog   = 1'b1;
               end else if (cnt_q == C_ONE) begin
                  nxt_state = S_GB;
                  nxt_cnt   = C_GB;
               end else begin
                  nxt_cnt = cnt_q - C_ONE;
               end
            end
            S_GB: begin
               if (flash_en || cnt_q == C_ONE) begin
                  nxt_state = S_YB;
                  nxt_cnt   = C_Y;
               end else begin
                  nxt_cnt = cnt_q - C_ONE;
               end
            end
            S_YB: begin
               if (cnt_q == C_ONE) begin
                  nxt_state = S_AR2;
                  nxt_cnt   = C_AR;
               end else begin
                  nxt_cnt = cnt_q - C_ONE;
               end
            end
            S_AR2: begin
               if (cnt_q == C_ONE && flash_en) begin
                  nxt_state = S_FL;
                  nxt_cnt   = '0;
                  nxt_tog   = 1'b1;
               end else if (cnt_q == C_ONE) begin
                  nxt_state = S_GA;
                  nxt_cnt   = C_GA;
               end else begin
                  nxt_cnt = cnt_q - C_ONE;
               end
            end
            S_FL: begin
               if (!flash_en) begin
                  nxt_state = S_AR2;
                  nxt_cnt   = C_AR;
                  nxt_tog   = 1'b0;
               end else begin
                  nxt_tog = ~tog_q;
               end
            end
            default: begin
               // Illegal encoding: fall back to a safe all-red phase.
               nxt_state = S_AR2;
               nxt_cnt   = C_AR;
               nxt_tog   = 1'b0;
            end
         endcase
      end
   end

   assign clr_pend = tick && state_q != nxt_state &&
                     (nxt_state == S_GB || nxt_state == S_FL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tick_cnt  <= '0;
         state_q   <= S_GA;
         cnt_q     <= C_GA;
         tog_q     <= 1'b0;
         light_a_n <= L_GRN;
         light_b_n <= L_RED;
         walk      <= 1'b0;
         ped_pend  <= 1'b0;
      end else begin
         tick_cnt  <= tick ? '0 : tick_cnt + TW'(1);
         state_q   <= nxt_state;
         cnt_q     <= nxt_cnt;
         tog_q     <= nxt_tog;
         light_a_n <= lamp_a(nxt_state, nxt_tog);
         light_b_n <= lamp_b(nxt_state, nxt_tog);
         walk      <= (nxt_state == S_GB);
         // Clearing on GREEN_B/FLASH entry beats a same-cycle request.
         if (clr_pend)
            ped_pend <= 1'b0;
         else if (ped_req && state_q != S_FL)
            ped_pend <= 1'b1;
      end
   end

endmodule

// File: tb/tb_traffic_ctrl.sv
// Directed bench for traffic_ctrl: expected phase outputs are queued
// before each tick and popped/compared once the tick has been taken.
module tb_traffic_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ped_req;
   logic       flash_en;
   logic [2:0] light_a_n;
   logic [2:0] light_b_n;
   logic       walk;
   logic       ped_pend;
   logic [7:0] countdown;
   logic [2:0] state;

   typedef struct {
      logic [2:0] st;
      logic [7:0] cd;
      logic [2:0] la;
      logic [2:0] lb;
      logic       wk;
      logic       pd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;
   int   ph;
   int   wclks = 0;
   int   w0;

   traffic_ctrl #(
      .TICK_DIV (4),
      .T_GREEN_A(5),
      .T_GREEN_B(4),
      .T_YELLOW (2),
      .T_ALLRED (1),
      .T_PED_MIN(2),
      .CNT_W    (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ped_req  (ped_req),
      .flash_en (flash_en),
      .light_a_n(light_a_n),
      .light_b_n(light_b_n),
      .walk     (walk),
      .ped_pend (ped_pend),
      .countdown(countdown),
      .state    (state)
   );

   always #5 clk = ~clk;

   // Bench-side tick phase: the tick is taken on the edge where ph==3.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ph <= 0;
      else        ph <= (ph == 3) ? 0 : ph + 1;
   end

   always @(posedge clk) if (walk === 1'b1) wclks++;

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   function automatic logic [2:0] la_of(input int s, input bit t);
      case (s)
         0: return 3'b110;
         1: return 3'b101;
         6: return t ? 3'b101 : 3'b111;
         default: return 3'b011;
      endcase
   endfunction

   function automatic logic [2:0] lb_of(input int s, input bit t);
      case (s)
         3: return 3'b110;
         4: return 3'b101;
         6: return t ? 3'b101 : 3'b111;
         default: return 3'b011;
      endcase
   endfunction

   task automatic push(input int s, input int cd, input bit pd,
                       input bit t = 1'b0);
      exp_t e;
      e.st = 3'(s);
      e.cd = 8'(cd);
      e.la = la_of(s, t);
      e.lb = lb_of(s, t);
      e.wk = (s == 3);
      e.pd = pd;
      sb.push_back(e);
   endtask

   task automatic cmp(input string tag, input string f,
                      input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s.%s got=%0h exp=%0h", tag, f, got, exp);
      end
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      checks++;
      assert (sb.size() != 0) else begin
         fails++;
         $error("FAIL %s.queue got=empty exp=entry", tag);
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         cmp(tag, "state", 8'(state), 8'(e.st));
         cmp(tag, "cd", countdown, e.cd);
         cmp(tag, "la", 8'(light_a_n), 8'(e.la));
         cmp(tag, "lb", 8'(light_b_n), 8'(e.lb));
         cmp(tag, "walk", 8'(walk), 8'(e.wk));
         cmp(tag, "pend", 8'(ped_pend), 8'(e.pd));
      end
   endtask

   task automatic next_tick();
      while (ph != 3) @(negedge clk);
      @(negedge clk);
   endtask

   task automatic tk(input string tag, input int s, input int cd,
                     input bit pd, input bit t = 1'b0);
      push(s, cd, pd, t);
      next_tick();
      pop_chk(tag);
   endtask

   task automatic now(input string tag, input int s, input int cd,
                      input bit pd, input bit t = 1'b0);
      push(s, cd, pd, t);
      pop_chk(tag);
   endtask

   initial begin
      rst_n    = 1'b0;
      ped_req  = 1'b0;
      flash_en = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      now("rst", 0, 5, 0);

      // full normal cycle
      tk("t1_ga4", 0, 4, 0);
      tk("t1_ga3", 0, 3, 0);
      tk("t1_ga2", 0, 2, 0);
      tk("t1_ga1", 0, 1, 0);
      tk("t1_ya2", 1, 2, 0);
      tk("t1_ya1", 1, 1, 0);
      tk("t1_ar1", 2, 1, 0);
      tk("t1_gb4", 3, 4, 0);
      tk("t1_gb3", 3, 3, 0);
      tk("t1_gb2", 3, 2, 0);
      tk("t1_gb1", 3, 1, 0);
      tk("t1_yb2", 4, 2, 0);
      tk("t1_yb1", 4, 1, 0);
      tk("t1_ar2", 5, 1, 0);
      tk("t1_ga5", 0, 5, 0);

      // pedestrian shortens main green
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      now("t2_pend", 0, 5, 1);
      w0 = wclks;
      tk("t2_ga2", 0, 2, 1);
      tk("t2_ga1", 0, 1, 1);
      tk("t2_ya2", 1, 2, 1);
      tk("t2_ya1", 1, 1, 1);
      tk("t2_ar1", 2, 1, 1);
      tk("t2_gb4", 3, 4, 0);
      tk("t2_gb3", 3, 3, 0);
      tk("t2_gb2", 3, 2, 0);
      tk("t2_gb1", 3, 1, 0);
      tk("t2_yb2", 4, 2, 0);
      tk("t2_yb1", 4, 1, 0);
      tk("t2_ar2", 5, 1, 0);
      tk("t2_ga5", 0, 5, 0);
      cmp("t2", "walk_clks", 8'(wclks - w0), 8'd16);

      // late request: no truncation; request on GREEN_B entry dropped
      tk("t3_ga4", 0, 4, 0);
      tk("t3_ga3", 0, 3, 0);
      tk("t3_ga2", 0, 2, 0);
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      now("t3_pend", 0, 2, 1);
      tk("t3_ga1", 0, 1, 1);
      tk("t3_ya2", 1, 2, 1);
      tk("t3_ya1", 1, 1, 1);
      tk("t3_ar1", 2, 1, 1);
      while (ph != 3) @(negedge clk);
      ped_req = 1'b1;
      push(3, 4, 0);
      @(negedge clk);
      ped_req = 1'b0;
      pop_chk("t3_clr");
      @(negedge clk);
      now("t3_hold", 3, 4, 0);

      // night flash
      tk("t4_gb3", 3, 3, 0);
      flash_en = 1'b1;
      tk("t4_yb2", 4, 2, 0);
      tk("t4_yb1", 4, 1, 0);
      tk("t4_ar2", 5, 1, 0);
      tk("t4_fl1", 6, 0, 0, 1);
      @(negedge clk);
      now("t4_hold", 6, 0, 0, 1);
      ped_req = 1'b1;
      @(negedge clk);
      ped_req = 1'b0;
      now("t4_noped", 6, 0, 0, 1);
      tk("t4_fl0", 6, 0, 0, 0);
      tk("t4_fl1b", 6, 0, 0, 1);
      flash_en = 1'b0;
      tk("t4_ar2x", 5, 1, 0);
      tk("t4_ga5", 0, 5, 0);

      // async reset mid YELLOW_A
      tk("t5_ga4", 0, 4, 0);
      tk("t5_ga3", 0, 3, 0);
      tk("t5_ga2", 0, 2, 0);
      tk("t5_ga1", 0, 1, 0);
      tk("t5_ya2", 1, 2, 0);
      #3 rst_n = 1'b0;
      #1 now("t5_rst", 0, 5, 0);
      @(negedge clk);
      rst_n = 1'b1;
      now("t5_rel", 0, 5, 0);
      tk("t5_ga4b", 0, 4, 0);

      // illegal state recovery
      force dut.state_q = 3'd7;
      #1 release dut.state_q;
      tk("t6_rec", 5, 1, 0);
      tk("t6_ga5", 0, 5, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule

// File: doc/traffic_ctrl.md
Name: traffic_ctrl

Overview:
Parametrised two-road traffic-light controller: road A (main) and road B (side). It generalises the fixed 4-phase controller with several additions:
- configurable phase durations
- all-red clearance phases
- internal clock-enable tick instead of a derived clock
- latched pedestrian request that shortens main green
- night flashing-yellow mode
- a live countdown output for the 7-seg display

It sits between board switches/keys and the LED/segment drivers.

Parameters:
TICK_DIV, 12000000, clk cycles per 1 s tick (>=2)
T_GREEN_A, 10, road-A green duration in ticks (>=1)
T_GREEN_B, 8, road-B green duration in ticks (>=1)
T_YELLOW, 3, yellow duration in ticks, both roads (>=1)
T_ALLRED, 1, all-red clearance duration in ticks (>=1)
T_PED_MIN, 3, minimum remaining A-green after pedestrian request (>=1, <=T_GREEN_A)
CNT_W, 8, countdown width; must hold max duration

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ped_req  in  1  pedestrian button (synchronous, already debounced), level or pulse
flash_en  in  1  night-mode request, level
light_a_n  out  3  road A lamps, active-low, {red,yellow,green}
light_b_n  out  3  road B lamps, active-low, {red,yellow,green}
walk  out  1  pedestrian walk lamp, active-high
ped_pend  out  1  pedestrian request latched, not yet served
countdown  out  CNT_W  remaining ticks in current phase (0 in FLASH)
state  out  3  current state encoding, for debug/display

Behaviour:
- Single clock domain. Async reset clears/loads every register. All outputs are registered.
- Reset values:
  - state=GREEN_A(0); countdown=T_GREEN_A
  - light_a_n=3'b110; light_b_n=3'b011
  - walk=0; ped_pend=0
  - tick counter=0; flash toggle=0
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - tick = 1-cycle pulse when counter==TICK_DIV-1.
  - All state/countdown changes occur only on tick cycles.
- States and encodings: GREEN_A=0, YELLOW_A=1, ALLRED_1=2, GREEN_B=3, YELLOW_B=4, ALLRED_2=5, FLASH=6. Encoding 7 is illegal and recovers to ALLRED_2 on next tick.
- Lamps per state (A / B):
  - GREEN_A: G / R
  - YELLOW_A: Y / R
  - ALLRED_x: R / R
  - GREEN_B: R / G
  - YELLOW_B: R / Y
  - FLASH: Y / Y, toggling; lamps are all off when the toggle is 0
- Countdown rule:
  - On entry to a timed state, countdown loads that state's duration.
  - On each tick: if countdown==1, transition and load the next duration; else decrement.
  - A phase therefore lasts exactly T_x ticks and displays T_x..1.
- Normal sequence: GREEN_A -> YELLOW_A -> ALLRED_1 -> GREEN_B -> YELLOW_B -> ALLRED_2 -> GREEN_A.
- Pedestrian request:
  - ped_req=1 on any clock sets ped_pend, except in FLASH, where it is ignored.
  - In GREEN_A with ped_pend=1 and countdown>T_PED_MIN, the next tick loads T_PED_MIN instead of decrementing. This happens once only; later ticks decrement normally.
  - ped_pend clears on the cycle GREEN_B is entered. A ped_req in that same cycle is dropped (clear wins).
  - walk=1 exactly while state==GREEN_B.
- Flash mode:
  - If flash_en is sampled 1 at a tick in GREEN_x, the controller moves to YELLOW_x, truncating green.
  - YELLOW and ALLRED phases complete their full durations.
  - Exit from ALLRED_1 or ALLRED_2 while flash_en=1 goes to FLASH. ped_pend clears on FLASH entry.
  - In FLASH: toggle inverts every tick; countdown=0.
  - flash_en sampled 0 at a tick in FLASH -> ALLRED_2 with T_ALLRED, then GREEN_A.
- Reset mid-operation: immediate return to reset values. The tick phase restarts from 0.

Test Plan:
Test parameters: TICK_DIV=4, T_GREEN_A=5, T_GREEN_B=4, T_YELLOW=2, T_ALLRED=1, T_PED_MIN=2, CNT_W=8.
1. Reset release, no inputs:
   - state sequence 0,1,2,3,4,5,0 with dwell of 5,2,1,4,2,1 ticks.
   - Full cycle = 60 clks; countdown 5,4,3,2,1 in GREEN_A.
   - light_a_n=110 / light_b_n=011 after reset.
2. ped_req pulse at GREEN_A countdown=5:
   - ped_pend=1; next tick countdown=2, then 1, then YELLOW_A.
   - walk=1 for 16 clks in GREEN_B; ped_pend=0 from GREEN_B entry.
3. ped_req with countdown=2 -> no truncation; ped_req the same cycle as GREEN_B entry -> ped_pend stays 0.
4. flash_en=1 mid GREEN_B -> next tick YELLOW_B(2), ALLRED_2(1), FLASH.
   - Lamps alternate 101/101 and 111/111 every 4 clks; countdown=0.
   - Drop flash_en -> ALLRED_2 then GREEN_A with countdown=5.
5. rst_n low asynchronously mid YELLOW_A, not aligned to clk -> outputs reach reset values before the next clk edge; tick counter restarts.
6. Force state=7 via bench -> next tick state=ALLRED_2, lamps 011/011.
